// File: rtl/power_of_2k_pipe.sv
// Pipelined x^(2^STAGES): one squaring per stage with a per-stage valid/ready enable.
// Define POW_SATURATE_EN to saturate overflowed results to all ones and report o_ovf.
module power_of_2k_pipe #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned STAGES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DWIDTH-1:0] i_value,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DWIDTH-1:0] o_value,
  output logic              o_ovf
);

  logic [STAGES:1]   vld;
  logic [DWIDTH-1:0] dat [1:STAGES];
  logic [STAGES:1]   en;

  // Source of each stage: index 0 is the input port, index k is stage k.
  logic [STAGES-1:0] src_vld;
  logic [DWIDTH-1:0] src_dat [0:STAGES-1];
  logic [DWIDTH-1:0] nxt_dat [1:STAGES];

  always_comb begin
    src_vld[0] = i_valid;
    src_dat[0] = i_value;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld[k];
      src_dat[k] = dat[k];
    end
  end

  // A stage may advance if any stage at or after it holds a bubble, or the output drains.
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      en[k] = o_ready;
      for (int j = k; j <= STAGES; j++) begin
        if (!vld[j]) en[k] = 1'b1;
      end
    end
  end

`ifdef POW_SATURATE_EN
  logic [STAGES:1]   flg;
  logic [STAGES:1]   nxt_flg;
  logic [STAGES-1:0] src_flg;

  always_comb begin
    logic [2*DWIDTH-1:0] sq;
    sq = '0;
    src_flg[0] = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      src_flg[k] = flg[k];
    end
    for (int k = 1; k <= STAGES; k++) begin
      sq = {{DWIDTH{1'b0}}, src_dat[k-1]} * {{DWIDTH{1'b0}}, src_dat[k-1]};
      nxt_flg[k] = src_flg[k-1] | (|sq[2*DWIDTH-1:DWIDTH]);
      nxt_dat[k] = nxt_flg[k] ? {DWIDTH{1'b1}} : sq[DWIDTH-1:0];
    end
  end

  assign o_ovf = flg[STAGES];
`else
  // Wrapping mode: only the low half of each square is ever needed.
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      nxt_dat[k] = src_dat[k-1] * src_dat[k-1];
    end
  end

  assign o_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        dat[k] <= '0;
      end
`ifdef POW_SATURATE_EN
      flg <= '0;
`endif
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (en[k]) begin
          vld[k] <= src_vld[k-1];
          if (src_vld[k-1]) begin
            dat[k] <= nxt_dat[k];
`ifdef POW_SATURATE_EN
            flg[k] <= nxt_flg[k];
`endif
          end
        end
      end
    end
  end

  assign i_ready = en[1];
  assign o_valid = vld[STAGES];
  assign o_value = dat[STAGES];

endmodule

// File: tb/tb_power_of_2k_pipe.sv
// Self-checking bench for power_of_2k_pipe (DWIDTH=32, STAGES=3) with a queue scoreboard
// fed by an exact wide-arithmetic model of x^8.
module tb_power_of_2k_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned ST = 3;

  logic          clk;
  logic          reset_n;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_value;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_value;
  logic          o_ovf;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_val_q [$];
  logic          exp_ovf_q [$];

  logic          stall_seen;
  logic [DW-1:0] stall_val;
  logic          stall_ovf;

  power_of_2k_pipe #(
    .DWIDTH(DW),
    .STAGES(ST)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_value(i_value),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_value(o_value),
    .o_ovf  (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact x^(2^ST) in 256 bits, then reduced according to the overflow mode.
  function automatic void model(input logic [DW-1:0] x, output logic [DW-1:0] val,
                                output logic ovf);
    logic [255:0] p;
    logic         big;
    p = {224'b0, x};
    for (int s = 0; s < int'(ST); s++) p = p * p;
    big = |p[255:DW];
`ifdef POW_SATURATE_EN
    val = big ? {DW{1'b1}} : p[DW-1:0];
    ovf = big;
`else
    val = p[DW-1:0];
    ovf = 1'b0;
`endif
  endfunction

  // Negedge monitor: sees the handshakes that complete at the following rising edge.
  always @(negedge clk) begin
    logic [DW-1:0] ev;
    logic          eo;
    if (!reset_n) begin
      exp_val_q.delete();
      exp_ovf_q.delete();
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && o_valid) begin
        checks++;
        if (o_value !== stall_val || o_ovf !== stall_ovf) begin
          errors++;
          $display("FAIL stall_hold: got %h/%b required %h/%b", o_value, o_ovf, stall_val,
                   stall_ovf);
        end
      end
      stall_seen = o_valid && !o_ready;
      stall_val  = o_value;
      stall_ovf  = o_ovf;
      if (o_valid && o_ready) begin
        checks++;
        if (exp_val_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h with no sample outstanding", o_value);
        end else begin
          ev = exp_val_q.pop_front();
          eo = exp_ovf_q.pop_front();
          if (o_value !== ev || o_ovf !== eo) begin
            errors++;
            $display("FAIL scoreboard: got %h/%b required %h/%b", o_value, o_ovf, ev, eo);
          end
        end
      end
      if (i_valid && i_ready) begin
        model(i_value, ev, eo);
        exp_val_q.push_back(ev);
        exp_ovf_q.push_back(eo);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    i_valid = 1'b0;
    o_ready = 1'b1;
    while ((exp_val_q.size() != 0 || o_valid) && n < 50) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (exp_val_q.size() != 0 || o_valid) begin
      errors++;
      $display("FAIL %s_drain: %0d samples outstanding, required 0", name, exp_val_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_value = '0;
    o_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (o_valid !== 1'b0 || o_value !== '0 || o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h f=%b required 0/0/0", o_valid, o_value, o_ovf);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got i_ready=%b o_valid=%b required 1/0", i_ready, o_valid);
    end
  endtask

  // Single sample, latency and value checked against fixed constants.
  task automatic test_basic();
    logic [DW-1:0] xs   [3] = '{32'd2, 32'd3, 32'd15};
    logic [DW-1:0] exps [3] = '{32'd256, 32'd6561, 32'd2562890625};
    for (int t = 0; t < 3; t++) begin
      int lat;
      i_valid = 1'b1;
      i_value = xs[t];
      tick();
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 10) begin
        tick();
        lat++;
      end
      checks++;
      if (lat != 3 || o_value !== exps[t] || o_ovf !== 1'b0) begin
        errors++;
        $display("FAIL basic_x%0d: got lat=%0d d=%0d f=%b required lat=3 d=%0d f=0", xs[t],
                 lat, o_value, o_ovf, exps[t]);
      end
      tick();
    end
    drain("basic");
  endtask

  task automatic test_overflow();
    int lat;
    logic [DW-1:0] ev;
    logic          eo;
`ifdef POW_SATURATE_EN
    ev = 32'hFFFF_FFFF;
    eo = 1'b1;
`else
    ev = 32'h0;
    eo = 1'b0;
`endif
    i_valid = 1'b1;
    i_value = 32'd16;
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 3 || o_value !== ev || o_ovf !== eo) begin
      errors++;
      $display("FAIL overflow_x16: got lat=%0d d=%h f=%b required lat=3 d=%h f=%b", lat,
               o_value, o_ovf, ev, eo);
    end
    drain("overflow");
  endtask

  task automatic test_streaming();
    for (int p = 0; p < 14; p++) begin
      logic exp_v;
      if (p < 10) begin
        i_valid = 1'b1;
        i_value = DW'(p + 1);
        checks++;
        if (i_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_i_ready_%0d: got %b required 1", p, i_ready);
        end
      end else begin
        i_valid = 1'b0;
      end
      tick();
      exp_v = (p + 1 >= 3) && (p + 1 <= 12);
      checks++;
      if (o_valid !== exp_v) begin
        errors++;
        $display("FAIL stream_o_valid_%0d: got %b required %b", p, o_valid, exp_v);
      end
    end
    drain("stream");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] xs [4] = '{32'd2, 32'd3, 32'd4, 32'd5};
    int idx = 0;
    o_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      logic acc;
      i_valid = 1'b1;
      i_value = xs[idx];
      @(negedge clk);
      acc = i_ready;
      tick();
      if (acc) idx++;
    end
    checks++;
    if (idx != 3 || i_ready !== 1'b0 || o_valid !== 1'b1 || o_value !== 32'd256) begin
      errors++;
      $display("FAIL bp_full: got accepted=%0d i_ready=%b d=%0d required 3/0/256", idx,
               i_ready, o_value);
    end
    o_ready = 1'b1;
    #1;
    checks++;
    if (i_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept_when_full: got i_ready=%b required 1", i_ready);
    end
    tick();
    i_valid = 1'b0;
    drain("bp");
  endtask

  task automatic test_reset_midflight();
    int lat;
    i_valid = 1'b1;
    i_value = 32'd2;
    tick();
    i_value = 32'd3;
    tick();
    i_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #2;
    checks++;
    if (o_valid !== 1'b0 || o_value !== '0 || i_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_clear: got v=%b d=%h i_ready=%b required 0/0/1", o_valid,
               o_value, i_ready);
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet_%0d: got o_valid=%b required 0", c, o_valid);
      end
    end
    i_valid = 1'b1;
    i_value = 32'd4;
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 3 || o_value !== 32'd65536) begin
      errors++;
      $display("FAIL midreset_x4: got lat=%0d d=%0d required lat=3 d=65536", lat, o_value);
    end
    drain("midreset");
  endtask

  task automatic test_bubbles();
    logic exp_v [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int p = 0; p < 7; p++) begin
      i_valid = (p == 0) || (p == 2);
      i_value = (p == 0) ? 32'd2 : 32'd3;
      tick();
      checks++;
      if (o_valid !== exp_v[p]) begin
        errors++;
        $display("FAIL bubble_o_valid_%0d: got %b required %b", p, o_valid, exp_v[p]);
      end
      if (p == 2 || p == 4) begin
        checks++;
        if (o_value !== ((p == 2) ? 32'd256 : 32'd6561)) begin
          errors++;
          $display("FAIL bubble_value_%0d: got %0d", p, o_value);
        end
      end
    end
    drain("bubble");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_value = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 20)) : DW'($urandom);
      o_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
    test_bubbles();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/power_of_2k_pipe.md
POWER_OF_2K_PIPE -- requirements
Module: power_of_2k_pipe

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, operand/result width in bits (legal 8..64).
REQ-002 SHALL have parameter STAGES, default 3, number of squaring stages; result = x^(2^STAGES) (legal 1..5).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  input sample present.
REQ-006 SHALL have port i_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port i_value  input  DWIDTH  unsigned operand x.
REQ-008 SHALL have port o_valid  output  1  result present.
REQ-009 SHALL have port o_ready  input  1  downstream accepts result.
REQ-010 SHALL have port o_value  output  DWIDTH  unsigned result.
REQ-011 SHALL have port o_ovf  output  1  overflow flag accompanying o_value.

Function
REQ-012 SHALL implement STAGES register stages; stage k holds valid bit v[k], value d[k] = x^(2^k), flag f[k].
REQ-013 SHALL load stage 1 with i_value*i_value on input transfer (i_valid & i_ready); stage k>1 loads d[k-1]*d[k-1].
REQ-014 SHALL truncate each square to its low DWIDTH bits; f[k] = f[k-1] | (upper DWIDTH bits of square nonzero), f[0]=0.
REQ-015 SHALL drive o_valid = v[STAGES], o_value = d[STAGES], o_ovf = f[STAGES], all directly from registers.
REQ-016 SHALL advance stage k when v[k]=0 or stage k's data is consumed this cycle (bubble-collapsing, per-stage enable).
REQ-017 SHALL drive i_ready = !v[1] | stage-1 data consumed this cycle (combinational path from o_ready allowed).
REQ-018 SHALL clear v[k] when stage k is consumed and no new data loads; hold d/f/v unchanged when stalled.
REQ-019 SHALL have latency STAGES cycles from input transfer to o_valid with o_ready=1 throughout.
REQ-020 SHALL sustain one transfer per cycle when o_ready=1 continuously.
REQ-021 SHALL hold o_value/o_ovf stable while o_valid=1 and o_ready=0.
REQ-022 SHALL, when full (all v=1) and o_ready=1, accept a new input in the same cycle as output transfer.
REQ-023 SHALL preserve order; no sample dropped or duplicated.

Reset
REQ-024 SHALL on reset_n=0 asynchronously clear all v[k], d[k], f[k] to 0; o_valid=0, o_value=0, o_ovf=0, i_ready=1 after release.
REQ-025 SHALL discard in-flight samples on reset asserted mid-operation; first post-reset output is from a post-reset input.

Configuration
REQ-026 SHALL use macro POW_SATURATE_EN to select overflow handling.
REQ-027 SHALL, with POW_SATURATE_EN defined, force d[k] to all ones whenever f[k]=1 (saturation propagates to output) and report o_ovf.
REQ-028 SHALL, without POW_SATURATE_EN, output wrapped modulo-2^DWIDTH value and tie o_ovf to 0 (flag logic removed).

Verification
REQ-029 SHALL verify basic: DWIDTH=32, STAGES=3, o_ready=1, x=2 -> o_value=256 exactly 3 cycles later; x=3 -> 6561; x=15 -> 2562890625, o_ovf=0.
REQ-030 SHALL verify overflow: x=16 -> without macro o_value=0, o_ovf=0; with POW_SATURATE_EN o_value=0xFFFFFFFF, o_ovf=1.
REQ-031 SHALL verify streaming: x=1..10 on consecutive cycles, o_ready=1 -> results 1,256,6561,... on 10 consecutive cycles, i_ready constantly 1.
REQ-032 SHALL verify backpressure: o_ready=0 for 6 cycles, i_valid=1 with x=2,3,4,5 -> first three accepted, i_ready=0 on fourth; o_value=256 held; after o_ready=1 outputs 256,6561,65536,390625 in order.
REQ-033 SHALL verify reset mid-flight: inputs x=2,3 accepted, reset_n pulsed low 1 cycle after -> o_valid stays 0; next input x=4 -> 65536 after 3 cycles.
REQ-034 SHALL verify bubbles: i_valid toggling 1/0 with x=2,3 -> o_valid pattern 1,0,1 with 256, 6561, no duplicates.
